pixel_byte_demux: RTL

Receive-side counterpart of the per-channel output multiplexer. Accepts a byte-serial pixel stream in fixed R, G, B order and demultiplexes each byte into the write port of the matching R, G or B frame-buffer bank, generating a shared pixel write address. Sits between the byte-stream source (host/interface logic) and the three channel buffers, so the buffers are filled in the same format that the display-side mux later reads out.

---
 rtl/pixel_byte_demux.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pixel_byte_demux.sv
// Byte-serial R,G,B pixel stream demultiplexer: routes each byte to the
// write port of its channel bank and generates a shared pixel write address.
module pixel_byte_demux #(
   parameter int NUM_PIXELS = 307200,
   parameter int ADDR_W     = 19
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [7:0]        byteIn_i,
   input  logic              byteValid_i,
   input  logic              frameStart_i,
   output logic [7:0]        buf1InR_o,
   output logic [7:0]        buf1InG_o,
   output logic [7:0]        buf1InB_o,
   output logic              wrEnR_o,
   output logic              wrEnG_o,
   output logic              wrEnB_o,
   output logic [ADDR_W-1:0] wrAddr_o,
   output logic              pixelValid_o,
   output logic              frameDone_o,
   output logic              syncErr_o
);

   typedef enum logic [1:0] {
      EXP_R,
      EXP_G,
      EXP_B
   } chanState_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   chanState_e        state_q, state_d;
   logic [ADDR_W-1:0] pixAddr_q, pixAddr_d;
   logic [7:0]        bufR_q, bufR_d;
   logic [7:0]        bufG_q, bufG_d;
   logic [7:0]        bufB_q, bufB_d;
   logic              wrEnR_q, wrEnR_d;
   logic              wrEnG_q, wrEnG_d;
   logic              wrEnB_q, wrEnB_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic              pixelValid_q, pixelValid_d;
   logic              frameDone_q, frameDone_d;
   logic              syncErr_q, syncErr_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= EXP_R;
         pixAddr_q    <= '0;
         bufR_q       <= 8'h00;
         bufG_q       <= 8'h00;
         bufB_q       <= 8'h00;
         wrEnR_q      <= 1'b0;
         wrEnG_q      <= 1'b0;
         wrEnB_q      <= 1'b0;
         wrAddr_q     <= '0;
         pixelValid_q <= 1'b0;
         frameDone_q  <= 1'b0;
         syncErr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pixAddr_q    <= pixAddr_d;
         bufR_q       <= bufR_d;
         bufG_q       <= bufG_d;
         bufB_q       <= bufB_d;
         wrEnR_q      <= wrEnR_d;
         wrEnG_q      <= wrEnG_d;
         wrEnB_q      <= wrEnB_d;
         wrAddr_q     <= wrAddr_d;
         pixelValid_q <= pixelValid_d;
         frameDone_q  <= frameDone_d;
         syncErr_q    <= syncErr_d;
      end
   end

   // FrameStart overrides the channel sequence; a byte arriving with it is R of pixel 0.
   always_comb begin
      state_d      = state_q;
      pixAddr_d    = pixAddr_q;
      bufR_d       = bufR_q;
      bufG_d       = bufG_q;
      bufB_d       = bufB_q;
      wrEnR_d      = 1'b0;
      wrEnG_d      = 1'b0;
      wrEnB_d      = 1'b0;
      wrAddr_d     = wrAddr_q;
      pixelValid_d = 1'b0;
      frameDone_d  = 1'b0;
      syncErr_d    = 1'b0;

      if (frameStart_i) begin
         syncErr_d = (state_q != EXP_R) || (pixAddr_q != '0);
         pixAddr_d = '0;
         if (byteValid_i) begin
            wrEnR_d  = 1'b1;
            bufR_d   = byteIn_i;
            wrAddr_d = '0;
            state_d  = EXP_G;
         end else begin
            state_d = EXP_R;
         end
      end else if (byteValid_i) begin
         wrAddr_d = pixAddr_q;
         case (state_q)
            EXP_R: begin
               wrEnR_d = 1'b1;
               bufR_d  = byteIn_i;
               state_d = EXP_G;
            end
            EXP_G: begin
               wrEnG_d = 1'b1;
               bufG_d  = byteIn_i;
               state_d = EXP_B;
            end
            EXP_B: begin
               wrEnB_d      = 1'b1;
               bufB_d       = byteIn_i;
               pixelValid_d = 1'b1;
               state_d      = EXP_R;
               if (pixAddr_q == LAST_ADDR) begin
                  pixAddr_d   = '0;
                  frameDone_d = 1'b1;
               end else begin
                  pixAddr_d = pixAddr_q + ADDR_W'(1);
               end
            end
            default: begin
               state_d = EXP_R;
            end
         endcase
      end
   end

   assign buf1InR_o    = bufR_q;
   assign buf1InG_o    = bufG_q;
   assign buf1InB_o    = bufB_q;
   assign wrEnR_o      = wrEnR_q;
   assign wrEnG_o      = wrEnG_q;
   assign wrEnB_o      = wrEnB_q;
   assign wrAddr_o     = wrAddr_q;
   assign pixelValid_o = pixelValid_q;
   assign frameDone_o  = frameDone_q;
   assign syncErr_o    = syncErr_q;

endmodule
